// File: rtl/muntjac_hart_ctrl.sv
// rtl/muntjac_hart_ctrl.sv - per-hart reset sequencing, software reset and interrupt sync
// Staggers hart release after power-on, services software reset requests, gates synced irqs.
module muntjac_hart_ctrl #(
   parameter int unsigned NumHarts     = 2,
   parameter int unsigned ResetStagger = 16,
   parameter int unsigned SyncStages   = 2,
   parameter logic [63:0] HartIdBase   = 64'd0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumHarts-1:0]      hart_rst_req_i,
   input  logic [NumHarts-1:0]      irq_software_m_i,
   input  logic [NumHarts-1:0]      irq_timer_m_i,
   input  logic [NumHarts-1:0]      irq_external_m_i,
   input  logic [NumHarts-1:0]      irq_external_s_i,
   output logic [NumHarts-1:0]      hart_rst_no,
   output logic [NumHarts-1:0]      irq_software_m_o,
   output logic [NumHarts-1:0]      irq_timer_m_o,
   output logic [NumHarts-1:0]      irq_external_m_o,
   output logic [NumHarts-1:0]      irq_external_s_o,
   output logic [NumHarts*64-1:0]   hart_id_o,
   output logic                     boot_done_o,
   output logic                     busy_o
);

   localparam int unsigned CntW = $clog2(ResetStagger + 1);
   localparam int unsigned IdxW = $clog2(NumHarts + 1);
   localparam logic [CntW-1:0] CntReload = CntW'(ResetStagger - 1);
   localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumHarts - 1);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      SWRST = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [NumHarts-1:0]   pend_q, pend_d;
   logic [NumHarts-1:0]   act_q, act_d;
   logic [NumHarts-1:0]   rstn_q, rstn_d;
   logic                  done_q, done_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BOOT;
         cnt_q   <= CntReload;
         idx_q   <= '0;
         pend_q  <= '0;
         act_q   <= '0;
         rstn_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         rstn_q  <= rstn_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pend_d  = pend_q | hart_rst_req_i;
      act_d   = act_q;
      rstn_d  = rstn_q;
      done_d  = done_q;
      unique case (state_q)
         BOOT: begin
            if (cnt_q == '0) begin
               cnt_d = CntReload;
               for (int i = 0; i < NumHarts; i++) begin
                  if (IdxW'(i) == idx_q) rstn_d[i] = 1'b1;
               end
               idx_d = idx_q + IdxW'(1);
               if (idx_q == LastIdx) begin
                  done_d  = 1'b1;
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         RUN: begin
            if (|pend_q) begin
               // Requests arriving on the entry edge stay queued for the next round.
               state_d = SWRST;
               act_d   = pend_q;
               pend_d  = hart_rst_req_i;
               rstn_d  = rstn_q & ~pend_q;
               cnt_d   = CntReload;
            end
         end
         SWRST: begin
            pend_d = pend_q | (hart_rst_req_i & ~act_q);
            if (cnt_q == '0) begin
               rstn_d  = rstn_q | act_q;
               act_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = BOOT;
      endcase
   end

   logic [4*NumHarts-1:0] irq_in;
   logic [4*NumHarts-1:0] irq_out;
   logic [4*NumHarts-1:0] sync_q [SyncStages];

   assign irq_in = {irq_external_s_i, irq_external_m_i, irq_timer_m_i, irq_software_m_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Gating sits after the synchroniser so a released hart sees the current level at once.
   assign irq_out = sync_q[SyncStages-1] & {4{rstn_q}};

   assign irq_software_m_o = irq_out[0*NumHarts +: NumHarts];
   assign irq_timer_m_o    = irq_out[1*NumHarts +: NumHarts];
   assign irq_external_m_o = irq_out[2*NumHarts +: NumHarts];
   assign irq_external_s_o = irq_out[3*NumHarts +: NumHarts];

   for (genvar g = 0; g < NumHarts; g++) begin : g_hart_id
      assign hart_id_o[g*64 +: 64] = HartIdBase + 64'(g);
   end

   assign hart_rst_no = rstn_q;
   assign boot_done_o = done_q;
   assign busy_o      = (state_q != RUN);

endmodule

// File: tb/tb_muntjac_hart_ctrl.sv
// tb/tb_muntjac_hart_ctrl.sv - self-checking bench for muntjac_hart_ctrl
`timescale 1ns/1ps
module tb_muntjac_hart_ctrl;

   localparam int N  = 4;
   localparam int RS = 16;
   localparam int SS = 2;
   localparam logic [63:0] HID = 64'hFFFF_FFFF_FFFF_FFFE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req = '0, sw = '0, tm = '0, em = '0, es = '0;
   logic [N-1:0] rstn, sw_o, tm_o, em_o, es_o;
   logic [N*64-1:0] hid;
   logic done, busy;

   logic [1:0]   d2_zero = '0;
   logic [1:0]   d2_rstn, d2_sw_o, d2_tm_o, d2_em_o, d2_es_o;
   logic [127:0] d2_hid;
   logic         d2_done, d2_busy;

   int checks = 0;
   int failures = 0;

   muntjac_hart_ctrl #(.NumHarts(N), .ResetStagger(RS), .SyncStages(SS), .HartIdBase(HID)) dut (
      .clk_i(clk), .rst_i(rst), .hart_rst_req_i(req),
      .irq_software_m_i(sw), .irq_timer_m_i(tm), .irq_external_m_i(em), .irq_external_s_i(es),
      .hart_rst_no(rstn),
      .irq_software_m_o(sw_o), .irq_timer_m_o(tm_o), .irq_external_m_o(em_o), .irq_external_s_o(es_o),
      .hart_id_o(hid), .boot_done_o(done), .busy_o(busy)
   );

   muntjac_hart_ctrl #(.NumHarts(2), .ResetStagger(1), .SyncStages(3),
                       .HartIdBase(64'hFFFF_FFFF_FFFF_FFFF)) dut2 (
      .clk_i(clk), .rst_i(rst), .hart_rst_req_i(d2_zero),
      .irq_software_m_i(d2_zero), .irq_timer_m_i(d2_zero), .irq_external_m_i(d2_zero),
      .irq_external_s_i(d2_zero),
      .hart_rst_no(d2_rstn),
      .irq_software_m_o(d2_sw_o), .irq_timer_m_o(d2_tm_o), .irq_external_m_o(d2_em_o),
      .irq_external_s_o(d2_es_o),
      .hart_id_o(d2_hid), .boot_done_o(d2_done), .busy_o(d2_busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   // Inputs as seen by the DUT at each rising edge.
   logic         cap_rst = 1'b1;
   logic [N-1:0] cap_req = '0;
   logic [4*N-1:0] cap_irq = '0;
   always @(posedge clk) begin
      cap_rst <= rst;
      cap_req <= req;
      cap_irq <= {es, em, tm, sw};
   end

   // Model: edge number since reset release decides boot releases; a software reset is a
   // hold window [entry, entry+RS) over the mask pending at entry.
   int           edge_n;
   int           hold_end;
   logic [N-1:0] m_rstn, m_pend, m_act;
   bit           m_done;
   logic [4*N-1:0] hq[$];
   logic [4*N-1:0] e_irq;
   logic [4*N-1:0] pulled;

   initial begin
      forever begin
         @(negedge clk);
         if (rst || cap_rst) begin
            edge_n = 0; m_rstn = '0; m_pend = '0; m_act = '0; m_done = 0; hold_end = 0;
            hq = {};
            for (int s = 0; s < SS; s++) hq.push_back('0);
         end else begin
            edge_n++;
            if (m_act != '0) begin
               m_pend = m_pend | (cap_req & ~m_act);
               if (edge_n == hold_end) begin
                  m_rstn = m_rstn | m_act;
                  m_act  = '0;
               end
            end else if (m_done && m_pend != '0) begin
               m_rstn   = m_rstn & ~m_pend;
               m_act    = m_pend;
               m_pend   = cap_req;
               hold_end = edge_n + RS;
            end else begin
               m_pend = m_pend | cap_req;
               if (!m_done) begin
                  for (int i = 0; i < N; i++)
                     if (edge_n == (i + 1) * RS) m_rstn[i] = 1'b1;
                  if (edge_n == N * RS) m_done = 1;
               end
            end
            hq.push_back(cap_irq);
            pulled = hq.pop_front();
         end
         e_irq = hq[0] & {4{m_rstn}};
         chk("hart_rst_no", 64'(rstn), 64'(m_rstn));
         chk("busy", 64'(busy), 64'(!m_done || m_act != '0));
         chk("boot_done", 64'(done), 64'(m_done));
         chk("irq_out", 64'({es_o, em_o, tm_o, sw_o}), 64'(e_irq));
         for (int i = 0; i < N; i++) chk("hart_id", hid[i*64 +: 64], HID + 64'(i));
      end
   end

   initial begin
      wait_edges(3);
      chk("reset_rstn", 64'(rstn), 64'h0);
      chk("reset_busy", 64'(busy), 64'h1);
      chk("reset_done", 64'(done), 64'h0);
      rst = 1'b0;
      sw = 4'b1010;
      // Boot: dut2 (stagger 1) first, then dut at edges 16/32/48/64
      wait_edges(1);
      chk("d2_edge1", 64'(d2_rstn), 64'h1);
      wait_edges(1);
      chk("d2_edge2", 64'(d2_rstn), 64'h3);
      chk("d2_done", 64'(d2_done), 64'h1);
      chk("d2_id0", d2_hid[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("d2_id1_wrap", d2_hid[127:64], 64'h0);
      chk("id2_wrap", hid[2*64 +: 64], 64'h0);
      wait_edges(13);
      chk("boot_e15", 64'(rstn), 64'h0);
      wait_edges(1);
      chk("boot_e16", 64'(rstn), 64'h1);
      wait_edges(16);
      chk("boot_e32", 64'(rstn), 64'h3);
      wait_edges(31);
      chk("boot_e63", 64'(rstn), 64'h7);
      chk("done_e63", 64'(done), 64'h0);
      wait_edges(1);
      chk("boot_e64", 64'(rstn), 64'hF);
      chk("done_e64", 64'(done), 64'h1);
      chk("busy_e64", 64'(busy), 64'h0);
      // Software reset of hart 2
      req = 4'b0100;
      wait_edges(1);
      req = '0;
      wait_edges(1);
      chk("sw2_start", 64'(rstn), 64'hB);
      chk("sw2_busy", 64'(busy), 64'h1);
      wait_edges(15);
      chk("sw2_last", 64'(rstn), 64'hB);
      wait_edges(1);
      chk("sw2_end", 64'(rstn), 64'hF);
      chk("sw2_idle", 64'(busy), 64'h0);
      // Hart 1 reset, hart 0 queued behind it, duplicate hart 0 request ignored
      req = 4'b0010;
      wait_edges(1);
      req = '0;
      wait_edges(5);
      req = 4'b0001;
      wait_edges(1);
      req = '0;
      wait_edges(11);
      chk("q_rel1", 64'(rstn), 64'hF);
      chk("q_run_gap", 64'(busy), 64'h0);
      wait_edges(1);
      chk("q_hold0", 64'(rstn), 64'hE);
      wait_edges(3);
      req = 4'b0001;
      wait_edges(1);
      req = '0;
      wait_edges(12);
      chk("q_rel0", 64'(rstn), 64'hF);
      wait_edges(1);
      chk("dup_ignored", 64'(busy), 64'h0);
      // Timer irq on hart 3: sync latency, then gating during its reset
      tm = 4'b1000;
      wait_edges(1);
      chk("tm3_lat1", 64'(tm_o[3]), 64'h0);
      wait_edges(1);
      chk("tm3_lat2", 64'(tm_o[3]), 64'h1);
      req = 4'b1000;
      wait_edges(1);
      req = '0;
      wait_edges(1);
      chk("tm3_gated", 64'(tm_o[3]), 64'h0);
      tm = '0;
      wait_edges(4);
      tm = 4'b1000;
      wait_edges(11);
      chk("tm3_held", 64'(tm_o[3]), 64'h0);
      wait_edges(1);
      chk("tm3_release", 64'(tm_o[3]), 64'h1);
      for (int k = 0; k < 8; k++) begin
         sw = 4'(k);
         em = 4'(~k);
         es = 4'(k * 3);
         wait_edges(1);
      end
      // Async reset mid-boot after two releases, with a boot-time request
      sw = 4'b1111;
      rst = 1'b1;
      wait_edges(2);
      rst = 1'b0;
      wait_edges(40);
      chk("b2_e40", 64'(rstn), 64'h3);
      chk("b2_sw_on", 64'(sw_o), 64'h3);
      #1 rst = 1'b1;
      #1;
      chk("async_rstn", 64'(rstn), 64'h0);
      chk("async_irq", 64'({es_o, em_o, tm_o, sw_o}), 64'h0);
      chk("async_done", 64'(done), 64'h0);
      chk("async_busy", 64'(busy), 64'h1);
      wait_edges(1);
      rst = 1'b0;
      wait_edges(16);
      chk("b3_e16", 64'(rstn), 64'h1);
      wait_edges(4);
      req = 4'b0010;
      wait_edges(1);
      req = '0;
      wait_edges(43);
      chk("b3_e64", 64'(rstn), 64'hF);
      wait_edges(1);
      chk("boot_req_served", 64'(rstn), 64'hD);
      // Reset during SWRST with a request still pending: it must be dropped
      wait_edges(4);
      req = 4'b0001;
      wait_edges(1);
      req = '0;
      wait_edges(2);
      #1 rst = 1'b1;
      wait_edges(1);
      rst = 1'b0;
      wait_edges(64);
      chk("b4_e64", 64'(rstn), 64'hF);
      wait_edges(1);
      chk("b4_dropped_rstn", 64'(rstn), 64'hF);
      chk("b4_dropped_busy", 64'(busy), 64'h0);
      wait_edges(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muntjac_hart_ctrl.md
MUNTJAC_HART_CTRL -- requirements
Module: muntjac_hart_ctrl

Interface
REQ-001 SHALL have parameter NumHarts, default 2, meaning the number of cores controlled (legal range 1..16).
REQ-002 SHALL have parameter ResetStagger, default 16, meaning the reset hold/stagger interval in cycles (legal range >= 1).
REQ-003 SHALL have parameter SyncStages, default 2, meaning the interrupt synchroniser depth (legal range >= 2).
REQ-004 SHALL have parameter HartIdBase, default 64'd0, meaning the hart ID of hart 0.
REQ-005 SHALL have port clk_i, input, 1 bit, single clock for all logic.
REQ-006 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port hart_rst_req_i, input, NumHarts bits, a one-cycle pulse on bit i requests a software reset of hart i.
REQ-008 SHALL have ports irq_software_m_i, irq_timer_m_i, irq_external_m_i and irq_external_s_i, each input, NumHarts bits, asynchronous level interrupts.
REQ-009 SHALL have port hart_rst_no, output, NumHarts bits, active-low per-hart core reset.
REQ-010 SHALL have ports irq_software_m_o, irq_timer_m_o, irq_external_m_o and irq_external_s_o, each output, NumHarts bits, synchronised and gated interrupts.
REQ-011 SHALL have port hart_id_o, output, NumHarts*64 bits, where slice i carries the hart ID of hart i.
REQ-012 SHALL have port boot_done_o, output, 1 bit, high once every hart has been released from power-on reset.
REQ-013 SHALL have port busy_o, output, 1 bit, high while the FSM is in any state other than RUN.

Function
REQ-014 SHALL implement the FSM states BOOT, RUN and SWRST.
REQ-015 SHALL use a down-counter of width $clog2(ResetStagger+1) and a hart index of width $clog2(NumHarts+1).
REQ-016 SHALL, in BOOT, reload the counter to ResetStagger-1 at each terminal count and release (drive high) hart_rst_no[idx], then increment idx.
REQ-017 SHALL release hart i exactly (i+1)*ResetStagger cycles after the first rising edge following rst_i deassertion.
REQ-018 SHALL release harts strictly in ascending index order.
REQ-019 SHALL set boot_done_o on the same edge that releases the last hart, and SHALL then move to RUN.
REQ-020 SHALL hold boot_done_o high until rst_i is asserted.
REQ-021 SHALL OR hart_rst_req_i into a NumHarts-bit pending mask every cycle, in every state.
REQ-022 SHALL, in RUN with a nonzero pending mask, go to SWRST.
REQ-023 SHALL, on entry to SWRST, copy the pending mask into an active mask and clear the pending bits that were copied, while keeping any request that arrives on the same cycle.
REQ-024 SHALL, in SWRST, drive hart_rst_no low for every active hart for exactly ResetStagger cycles.
REQ-025 SHALL, at the end of SWRST, release all active harts simultaneously, clear the active mask and return to RUN.
REQ-026 SHALL re-enter SWRST on the next cycle if the pending mask is still nonzero.
REQ-027 SHALL keep requests received during BOOT pending and service them in the first SWRST after boot.
REQ-028 SHALL ignore a request for a hart that is already active in the current SWRST, so that the hold time is not extended.
REQ-029 SHALL pass each interrupt bit through a chain of SyncStages flops, giving a latency of SyncStages cycles.
REQ-030 SHALL force irq_*_o[i] to 0 whenever hart_rst_no[i] is 0, while the synchroniser keeps running.
REQ-031 SHALL drive hart_id_o slice i as the constant HartIdBase+i, computed modulo 2^64.
REQ-032 SHALL leave hart_rst_no[j] unchanged for every non-active hart j during SWRST.

Reset
REQ-033 SHALL, while rst_i is high, immediately drive hart_rst_no to all-zero, all irq_*_o to 0, boot_done_o to 0 and busy_o to 1.
REQ-034 SHALL, while rst_i is high, set the FSM to BOOT, the counter to ResetStagger-1, idx to 0, and the pending and active masks to 0.
REQ-035 SHALL, if rst_i is asserted during BOOT or SWRST, abort the operation, drop pending requests and restart the boot sequence after deassertion.
REQ-036 SHALL clear all synchroniser flops on reset.

Verification
REQ-037 SHALL cover: NumHarts=4, ResetStagger=16, release rst_i -> hart_rst_no bits rise at cycles 16, 32, 48 and 64, and boot_done_o rises at cycle 64.
REQ-038 SHALL cover: in RUN, pulse hart_rst_req_i=4'b0100 -> hart 2 is low for 16 cycles, the other harts stay high, and busy_o is high for those 16 cycles.
REQ-039 SHALL cover: pulse 4'b0001 during SWRST servicing 4'b0010 -> hart 1 is released, then one RUN cycle, then hart 0 is held for 16 cycles.
REQ-040 SHALL cover: irq_timer_m_i[3] rises while hart 3 is running -> irq_timer_m_o[3] rises 2 cycles later; asserting it during hart 3 reset -> output stays 0 until release.
REQ-041 SHALL cover: rst_i asserted asynchronously mid-BOOT after 2 releases -> all outputs return to reset values without waiting for a clock edge, and boot restarts from hart 0.
REQ-042 SHALL cover: HartIdBase=64'hFFFF_FFFF_FFFF_FFFF with NumHarts=2 -> hart_id_o slice 1 equals 0.
